// File: rtl/cnet_dma_rx_queue_pkg.sv
// Shared types and sizing helpers for the CNET->CPCI DMA receive queue.
package cnet_dma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        DRAIN
    } dma_state_e;

    // Largest payload that fits alongside its header word in a 2^depth_bits FIFO.
    function automatic logic [63:0] max_payload(input int unsigned depth_bits);
        return (64'd1 << depth_bits) - 64'd2;
    endfunction

    function automatic logic [63:0] bytes_to_words(input logic [63:0] nbytes);
        return (nbytes + 64'd3) >> 2;
    endfunction

endpackage

// File: rtl/cnet_dma_rx_queue_if.sv
// CNET capture / PCI drain bus of the DMA receive queue.
interface cnet_dma_rx_queue_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CHAN   = 4,
    parameter int unsigned CHAN_W     = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) ();
    logic [NUM_CHAN-1:0]   dma_request;
    logic [NUM_CHAN-1:0]   dma_pkt_avail;
    logic [NUM_CHAN-1:0]   cpci_dma_send;
    logic                  cpci_dma_wr_en;
    logic [DATA_WIDTH-1:0] cpci_dma_data;
    logic                  dma_rd_en;
    logic [DATA_WIDTH-1:0] dma_data;
    logic                  dma_empty;
    logic                  dma_nearly_empty;
    logic                  dma_nearly_full;
    logic                  dma_all_in_buf;
    logic [CHAN_W-1:0]     xfer_chan;
    logic                  len_err;
    logic                  timeout;

    modport master (
        output dma_request, dma_pkt_avail, cpci_dma_wr_en, cpci_dma_data, dma_rd_en,
        input  cpci_dma_send, dma_data, dma_empty, dma_nearly_empty, dma_nearly_full,
               dma_all_in_buf, xfer_chan, len_err, timeout
    );

    modport slave (
        input  dma_request, dma_pkt_avail, cpci_dma_wr_en, cpci_dma_data, dma_rd_en,
        output cpci_dma_send, dma_data, dma_empty, dma_nearly_empty, dma_nearly_full,
               dma_all_in_buf, xfer_chan, len_err, timeout
    );
endinterface

// File: rtl/cnet_dma_rx_queue_fifo.sv
// Single-clock packet FIFO: RAM, wrapping pointers, word count and level flags.
module cnet_dma_rx_fifo #(
    parameter int unsigned DATA_WIDTH          = 32,
    parameter int unsigned DEPTH_BITS          = 9,
    parameter int unsigned NEARLY_EMPTY_THRESH = 4,
    parameter int unsigned NEARLY_FULL_THRESH  = 8
) (
    input  logic                  pclk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [DEPTH_BITS:0]   count,
    output logic                  empty,
    output logic                  nearly_empty,
    output logic                  nearly_full
);
    localparam int unsigned         DEPTH     = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] MAX_COUNT = (DEPTH_BITS+1)'(DEPTH - 1);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE = DEPTH_BITS'(1);
    localparam logic [DEPTH_BITS:0]   CNT_ONE = (DEPTH_BITS+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS:0]   free;
    logic                  do_wr;
    logic                  do_rd;

    assign do_wr = wr_en && (count != MAX_COUNT);
    assign do_rd = rd_en && (count != '0);

    always_ff @(posedge pclk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                rd_data <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign free         = MAX_COUNT - count;
    assign empty        = (count == '0);
    assign nearly_empty = (count <= (DEPTH_BITS+1)'(NEARLY_EMPTY_THRESH));
    assign nearly_full  = (free  <= (DEPTH_BITS+1)'(NEARLY_FULL_THRESH));
endmodule

// File: rtl/cnet_dma_rx_queue.sv
// CNET->CPCI DMA receive queue: channel arbitration, header-checked capture, FIFO drain.
// Optional watchdog enabled by defining DMA_RX_TIMEOUT_EN.
module cnet_dma_rx_queue
    import cnet_dma_pkg::*;
#(
    parameter int unsigned DATA_WIDTH          = 32,
    parameter int unsigned DEPTH_BITS          = 9,
    parameter int unsigned NUM_CHAN            = 4,
    parameter int unsigned NEARLY_EMPTY_THRESH = 4,
    parameter int unsigned NEARLY_FULL_THRESH  = 8,
    parameter int unsigned TIMEOUT_CYCLES      = 1024
) (
    input  logic                 pclk,
    input  logic                 reset_n,
    cnet_dma_rx_queue_if.slave   bus
);
    localparam int unsigned CHAN_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam logic [DEPTH_BITS-1:0] REM_ONE = DEPTH_BITS'(1);

    dma_state_e            state;
    logic [NUM_CHAN-1:0]   pending;
    logic [NUM_CHAN-1:0]   ready;
    logic [NUM_CHAN-1:0]   grant_mask;
    logic [NUM_CHAN-1:0]   send;
    logic [CHAN_W-1:0]     grant_idx;
    logic [CHAN_W-1:0]     xfer_chan;
    logic                  grant_any;
    logic [DEPTH_BITS-1:0] remaining;
    logic [63:0]           hdr_words;
    logic                  hdr_ok;
    logic                  fifo_wr;
    logic                  fifo_empty;
    logic [DEPTH_BITS:0]   fifo_count;
    logic                  all_in_buf;
    logic                  len_err;
    logic                  tmo_fire;

    // Lowest-index channel with a latched request and a packet still available.
    always_comb begin
        ready      = pending & bus.dma_pkt_avail;
        grant_idx  = '0;
        grant_any  = 1'b0;
        grant_mask = '0;
        for (int unsigned i = 0; i < NUM_CHAN; i++) begin
            if (ready[i] && !grant_any) begin
                grant_idx = CHAN_W'(i);
                grant_any = 1'b1;
            end
        end
        if (state == IDLE && fifo_empty && grant_any) grant_mask[grant_idx] = 1'b1;
    end

    always_comb begin
        hdr_words = bytes_to_words(64'(bus.cpci_dma_data));
        hdr_ok    = (bus.cpci_dma_data != '0) && (hdr_words <= max_payload(DEPTH_BITS));
        fifo_wr   = bus.cpci_dma_wr_en && ((state == REQ && hdr_ok) || state == XFER);
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pending    <= '0;
            send       <= '0;
            xfer_chan  <= '0;
            remaining  <= '0;
            all_in_buf <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            pending <= (pending | bus.dma_request) & bus.dma_pkt_avail & ~grant_mask;
            if (tmo_fire) begin
                send       <= '0;
                all_in_buf <= 1'b0;
                state      <= IDLE;
            end else begin
                case (state)
                    IDLE: if (grant_mask != '0) begin
                        xfer_chan <= grant_idx;
                        send      <= grant_mask;
                        state     <= REQ;
                    end
                    REQ: if (bus.cpci_dma_wr_en) begin
                        send <= '0;
                        if (hdr_ok) begin
                            remaining <= hdr_words[DEPTH_BITS-1:0];
                            state     <= XFER;
                        end else begin
                            len_err <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                    XFER: if (bus.cpci_dma_wr_en) begin
                        remaining <= remaining - REM_ONE;
                        if (remaining == REM_ONE) begin
                            all_in_buf <= 1'b1;
                            state      <= DRAIN;
                        end
                    end
                    DRAIN: if (fifo_count == '0) begin
                        all_in_buf <= 1'b0;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef DMA_RX_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             timeout_q;
    logic             tmo_active;

    assign tmo_active = (state == REQ || state == XFER) && !bus.cpci_dma_wr_en;
    assign tmo_fire   = tmo_active && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
        end else if (tmo_fire) begin
            tmo_cnt   <= '0;
            timeout_q <= 1'b1;
        end else if (tmo_active) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end
    assign bus.timeout = timeout_q;
`else
    assign tmo_fire    = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    cnet_dma_rx_fifo #(
        .DATA_WIDTH          (DATA_WIDTH),
        .DEPTH_BITS          (DEPTH_BITS),
        .NEARLY_EMPTY_THRESH (NEARLY_EMPTY_THRESH),
        .NEARLY_FULL_THRESH  (NEARLY_FULL_THRESH)
    ) u_fifo (
        .pclk         (pclk),
        .reset_n      (reset_n),
        .wr_en        (fifo_wr),
        .wr_data      (bus.cpci_dma_data),
        .rd_en        (bus.dma_rd_en),
        .flush        (tmo_fire),
        .rd_data      (bus.dma_data),
        .count        (fifo_count),
        .empty        (fifo_empty),
        .nearly_empty (bus.dma_nearly_empty),
        .nearly_full  (bus.dma_nearly_full)
    );

    assign bus.cpci_dma_send  = send;
    assign bus.dma_empty      = fifo_empty;
    assign bus.dma_all_in_buf = all_in_buf;
    assign bus.xfer_chan      = xfer_chan;
    assign bus.len_err        = len_err;
endmodule

// File: tb/tb_cnet_dma_rx_queue.sv
// Directed self-checking bench for cnet_dma_rx_queue (watchdog steps need DMA_RX_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_cnet_dma_rx_queue;
    import cnet_dma_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned NC = 4;
    localparam int unsigned DB = 9;

    logic        pclk    = 1'b0;
    logic        reset_n = 1'b0;
    int unsigned errors  = 0;
    int unsigned checks  = 0;

    cnet_dma_rx_queue_if #(.DATA_WIDTH(DW), .NUM_CHAN(NC)) bus ();

    cnet_dma_rx_queue #(
        .DATA_WIDTH          (DW),
        .DEPTH_BITS          (DB),
        .NUM_CHAN            (NC),
        .NEARLY_EMPTY_THRESH (4),
        .NEARLY_FULL_THRESH  (8),
        .TIMEOUT_CYCLES      (1024)
    ) dut (
        .pclk    (pclk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic request_chan(input logic [NC-1:0] req);
        bus.dma_request = req;
        tick();
        bus.dma_request = '0;
        tick();
    endtask

    task automatic put(input logic [DW-1:0] d);
        bus.cpci_dma_wr_en = 1'b1;
        bus.cpci_dma_data  = d;
        tick();
        bus.cpci_dma_wr_en = 1'b0;
    endtask

    initial begin
        int unsigned model_cnt;
        logic [DW-1:0] exp_word;

        bus.dma_request    = '0;
        bus.dma_pkt_avail  = '0;
        bus.cpci_dma_wr_en = 1'b0;
        bus.cpci_dma_data  = '0;
        bus.dma_rd_en      = 1'b0;

        #12;
        check("rst_send", 64'(bus.cpci_dma_send), 64'h0);
        check("rst_empty", 64'(bus.dma_empty), 64'h1);
        check("rst_nearly_empty", 64'(bus.dma_nearly_empty), 64'h1);
        check("rst_nearly_full", 64'(bus.dma_nearly_full), 64'h0);
        check("rst_all_in_buf", 64'(bus.dma_all_in_buf), 64'h0);
        check("rst_len_err", 64'(bus.len_err), 64'h0);
        check("rst_timeout", 64'(bus.timeout), 64'h0);
        check("rst_dma_data", 64'(bus.dma_data), 64'h0);
        check("rst_xfer_chan", 64'(bus.xfer_chan), 64'h0);
        reset_n = 1'b1;
        tick();

        // Full-size packet on channel 0
        bus.dma_pkt_avail = 4'b0001;
        bus.dma_request   = 4'b0001;
        tick();
        bus.dma_request = '0;
        check("send_before_grant", 64'(bus.cpci_dma_send), 64'h0);
        tick();
        check("send_grant_ch0", 64'(bus.cpci_dma_send), 64'h1);
        check("xfer_chan_0", 64'(bus.xfer_chan), 64'h0);
        check("empty_at_grant", 64'(bus.dma_empty), 64'h1);
        check("state_req", 64'(dut.state), 64'(REQ));
        tick();
        tick();
        check("send_held", 64'(bus.cpci_dma_send), 64'h1);

        put(32'd2040);
        check("send_drop_hdr", 64'(bus.cpci_dma_send), 64'h0);
        check("state_xfer", 64'(dut.state), 64'(XFER));
        check("not_empty_hdr", 64'(bus.dma_empty), 64'h0);
        for (int unsigned i = 0; i < 510; i++) begin
            put(DW'(i));
            if (i == 500) check("nearly_full_free9", 64'(bus.dma_nearly_full), 64'h0);
            if (i == 501) check("nearly_full_free8", 64'(bus.dma_nearly_full), 64'h1);
            if (i == 508) check("all_in_buf_early", 64'(bus.dma_all_in_buf), 64'h0);
        end
        check("all_in_buf_full", 64'(bus.dma_all_in_buf), 64'h1);
        check("nearly_full_end", 64'(bus.dma_nearly_full), 64'h1);
        check("count_511", 64'(dut.u_fifo.count), 64'd511);
        check("state_drain", 64'(dut.state), 64'(DRAIN));
        put(32'hDEAD);
        check("drain_wr_ignored", 64'(dut.u_fifo.count), 64'd511);

        model_cnt = 511;
        bus.dma_rd_en = 1'b1;
        for (int unsigned k = 0; k < 511; k++) begin
            tick();
            model_cnt--;
            exp_word = (k == 0) ? 32'd2040 : DW'(k - 1);
            check("rd_data", 64'(bus.dma_data), 64'(exp_word));
            check("rd_nearly_empty", 64'(bus.dma_nearly_empty), 64'(model_cnt <= 4));
            check("rd_empty", 64'(bus.dma_empty), 64'(model_cnt == 0));
        end
        tick();
        bus.dma_rd_en = 1'b0;
        check("rd_while_empty_hold", 64'(bus.dma_data), 64'd509);
        check("state_idle_after_drain", 64'(dut.state), 64'(IDLE));
        check("all_in_buf_clear", 64'(bus.dma_all_in_buf), 64'h0);

        // Arbitration: ch1 before ch3; ch0 requested without a packet
        bus.dma_pkt_avail = 4'b1010;
        request_chan(4'b1011);
        check("send_grant_ch1", 64'(bus.cpci_dma_send), 64'h2);
        check("xfer_chan_1", 64'(bus.xfer_chan), 64'h1);
        put(32'd8);
        put(32'hA1);
        put(32'hA2);
        check("ch1_all_in_buf", 64'(bus.dma_all_in_buf), 64'h1);
        bus.dma_rd_en = 1'b1;
        tick();
        check("ch1_hdr", 64'(bus.dma_data), 64'd8);
        tick();
        check("ch1_w0", 64'(bus.dma_data), 64'hA1);
        tick();
        check("ch1_w1", 64'(bus.dma_data), 64'hA2);
        bus.dma_rd_en = 1'b0;
        tick();
        check("ch3_not_yet", 64'(bus.cpci_dma_send), 64'h0);
        tick();
        check("send_grant_ch3", 64'(bus.cpci_dma_send), 64'h8);
        check("xfer_chan_3", 64'(bus.xfer_chan), 64'h3);
        put(32'd4);
        put(32'h55);
        check("ch3_state_drain", 64'(dut.state), 64'(DRAIN));
        bus.dma_rd_en = 1'b1;
        tick();
        check("ch3_hdr", 64'(bus.dma_data), 64'd4);
        tick();
        check("ch3_w0", 64'(bus.dma_data), 64'h55);
        bus.dma_rd_en = 1'b0;
        tick();
        bus.dma_pkt_avail = 4'b1111;
        tick();
        tick();
        tick();
        check("ch0_never_granted", 64'(bus.cpci_dma_send), 64'h0);
        check("ch0_state_idle", 64'(dut.state), 64'(IDLE));

        // Header length errors
        bus.dma_pkt_avail = 4'b0001;
        request_chan(4'b0001);
        check("lenerr_pre", 64'(bus.len_err), 64'h0);
        put(32'd0);
        check("lenerr_zero", 64'(bus.len_err), 64'h1);
        check("lenerr_zero_send", 64'(bus.cpci_dma_send), 64'h0);
        check("lenerr_zero_idle", 64'(dut.state), 64'(IDLE));
        check("lenerr_zero_empty", 64'(bus.dma_empty), 64'h1);
        request_chan(4'b0001);
        check("lenerr_regrant", 64'(bus.cpci_dma_send), 64'h1);
        put(32'd2048);
        check("lenerr_big_idle", 64'(dut.state), 64'(IDLE));
        check("lenerr_big_empty", 64'(bus.dma_empty), 64'h1);
        check("lenerr_big_send", 64'(bus.cpci_dma_send), 64'h0);
        request_chan(4'b0001);
        put(32'd2041);
        check("lenerr_511_idle", 64'(dut.state), 64'(IDLE));
        check("lenerr_511_empty", 64'(bus.dma_empty), 64'h1);

        // Simultaneous read and write at count 3
        request_chan(4'b0001);
        put(32'd12);
        put(32'hA0);
        put(32'hA1);
        check("simul_pre_count", 64'(dut.u_fifo.count), 64'd3);
        bus.dma_rd_en = 1'b1;
        put(32'hA2);
        check("simul_count", 64'(dut.u_fifo.count), 64'd3);
        check("simul_data", 64'(bus.dma_data), 64'd12);
        check("simul_all_in_buf", 64'(bus.dma_all_in_buf), 64'h1);
        tick();
        check("simul_w0", 64'(bus.dma_data), 64'hA0);
        tick();
        check("simul_w1", 64'(bus.dma_data), 64'hA1);
        tick();
        check("simul_w2", 64'(bus.dma_data), 64'hA2);
        bus.dma_rd_en = 1'b0;
        tick();
        check("simul_idle", 64'(dut.state), 64'(IDLE));

        // Asynchronous reset in the middle of a transfer
        request_chan(4'b0001);
        put(32'd40);
        put(32'h1);
        put(32'h2);
        check("mid_xfer_not_empty", 64'(bus.dma_empty), 64'h0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_empty", 64'(bus.dma_empty), 64'h1);
        check("async_send", 64'(bus.cpci_dma_send), 64'h0);
        check("async_len_err", 64'(bus.len_err), 64'h0);
        check("async_state", 64'(dut.state), 64'(IDLE));
        #3;
        reset_n = 1'b1;
        tick();

`ifdef DMA_RX_TIMEOUT_EN
        request_chan(4'b0001);
        check("tmo_grant", 64'(bus.cpci_dma_send), 64'h1);
        repeat (1023) tick();
        check("tmo_req_before", 64'(bus.timeout), 64'h0);
        check("tmo_req_send_held", 64'(bus.cpci_dma_send), 64'h1);
        tick();
        check("tmo_req_fired", 64'(bus.timeout), 64'h1);
        check("tmo_req_send", 64'(bus.cpci_dma_send), 64'h0);
        check("tmo_req_idle", 64'(dut.state), 64'(IDLE));
        request_chan(4'b0001);
        put(32'd40);
        put(32'h1);
        put(32'h2);
        repeat (1023) tick();
        check("tmo_xfer_before", 64'(bus.dma_empty), 64'h0);
        tick();
        check("tmo_xfer_flush", 64'(bus.dma_empty), 64'h1);
        check("tmo_xfer_idle", 64'(dut.state), 64'(IDLE));
        check("tmo_xfer_all_in_buf", 64'(bus.dma_all_in_buf), 64'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
